// File: rtl/cic_decimator_pkg.sv
// ============================================================================
// Module  : cic_pkg
// Brief   : Shared limits, derived-width helper and stage-valid vector type
//           for the sinc^N CIC decimator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cic_pkg;

    localparam int ORDER_MAX    = 5;
    localparam int DEC_LOG2_MAX = 8;

    // One valid flag per comb stage, sized for the largest legal order.
    typedef logic [ORDER_MAX-1:0] cic_stage_vld_t;

    // Accumulator width: R^N gain needs ORDER*DEC_LOG2 bits of growth, plus
    // sign and one guard bit so that +/-R^N is representable.
    function automatic int cic_acc_w(input int order, input int dec_log2);
        return order * dec_log2 + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cic_decimator_if.sv
// ============================================================================
// Module  : cic_decimator_if
// Brief   : Bitstream input and decimated-sample valid/ready output bundle.
//           ovr_cnt exists only when CIC_OVR_CNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cic_decimator_if
    import cic_pkg::*;
#(
    parameter int ORDER    = 3,
    parameter int DEC_LOG2 = 4
) ();

    localparam int ACC_W = cic_acc_w(ORDER, DEC_LOG2);

    logic                    din;
    logic                    din_valid;
    logic signed [ACC_W-1:0] dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    ovr;
`ifdef CIC_OVR_CNT_EN
    logic [7:0]              ovr_cnt;
`endif

    // Filter side: consumes the bitstream, produces decimated samples.
    modport slave (
        input  din,
        input  din_valid,
        input  dout_ready,
        output dout,
        output dout_valid,
`ifdef CIC_OVR_CNT_EN
        output ovr_cnt,
`endif
        output ovr
    );

    // Environment side: supplies the bitstream, consumes samples.
    modport master (
        output din,
        output din_valid,
        output dout_ready,
        input  dout,
        input  dout_valid,
`ifdef CIC_OVR_CNT_EN
        input  ovr_cnt,
`endif
        input  ovr
    );

endinterface

`default_nettype wire

// File: rtl/cic_decimator_comb_stage.sv
// ============================================================================
// Module  : cic_comb_stage
// Brief   : One CIC comb section y = x - D, D <= x on each valid sample.
//           The difference is combinational; the pipeline register that
//           follows it lives in the parent so the final stage can feed the
//           output holding register directly.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_comb_stage #(
    parameter int W = 14
) (
    input  wire logic                CLK,
    input  wire logic                RST,
    input  wire logic                in_valid,
    input  wire logic signed [W-1:0] x,
    output logic                     out_valid,
    output logic signed [W-1:0]      y
);

    logic signed [W-1:0] r_dly;

    assign y         = x - r_dly;
    assign out_valid = in_valid;

    // Delay element advances only on decimated samples.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_dly <= '0;
        end else if (in_valid) begin
            r_dly <= x;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cic_decimator.sv
// ============================================================================
// Module  : cic_decimator
// Brief   : Parametrised sinc^N CIC decimator for a 1-bit sigma-delta
//           bitstream, R = 2^DEC_LOG2, valid/ready output with sticky
//           overwrite flag. Define CIC_OVR_CNT_EN to add the saturating
//           8-bit overwrite counter ovr_cnt.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_decimator
    import cic_pkg::*;
#(
    parameter int ORDER    = 3,
    parameter int DEC_LOG2 = 4
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    cic_decimator_if.slave  bus
);

    localparam int             ACC_W       = cic_acc_w(ORDER, DEC_LOG2);
    localparam cic_stage_vld_t C_LAST_MASK = cic_stage_vld_t'(1) << (ORDER - 1);

    if (ORDER < 1 || ORDER > ORDER_MAX) begin : g_bad_order
        $error("cic_decimator: ORDER=%0d outside 1..%0d", ORDER, ORDER_MAX);
    end
    if (DEC_LOG2 < 1 || DEC_LOG2 > DEC_LOG2_MAX) begin : g_bad_dec
        $error("cic_decimator: DEC_LOG2=%0d outside 1..%0d", DEC_LOG2, DEC_LOG2_MAX);
    end

    logic signed [ACC_W-1:0] w_x;
    logic signed [ACC_W-1:0] w_integ [ORDER];
    logic [DEC_LOG2-1:0]     r_cnt;
    logic                    r_dec_stb;
    logic signed [ACC_W-1:0] w_cx [ORDER];
    logic [ORDER-1:0]        w_cv;
    logic signed [ACC_W-1:0] w_cy [ORDER];
    cic_stage_vld_t          w_ov;
    logic signed [ACC_W-1:0] w_res;
    logic                    w_res_v;
    logic                    w_overwrite;
    logic signed [ACC_W-1:0] r_dout;
    logic                    r_dout_valid;
    logic                    r_ovr;

    // Bit 1 maps to +1, bit 0 to -1.
    assign w_x = bus.din ? ACC_W'(1) : '1;

    // Integrator cascade; each stage adds the previous stage's registered value.
    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        logic signed [ACC_W-1:0] r_acc;
        logic signed [ACC_W-1:0] w_in;

        if (k == 0) begin : g_src_x
            assign w_in = w_x;
        end else begin : g_src_prev
            assign w_in = w_integ[k-1];
        end

        // Wrap-around accumulate on each qualified input sample.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                r_acc <= '0;
            end else if (bus.din_valid) begin
                r_acc <= r_acc + w_in;
            end
        end

        assign w_integ[k] = r_acc;
    end

    // Sample counter and decimation strobe, both sample-indexed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt     <= '0;
            r_dec_stb <= 1'b0;
        end else begin
            r_dec_stb <= bus.din_valid && (&r_cnt);
            if (bus.din_valid) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Comb chain; stage k is followed by a pipeline register except the last,
    // whose register is the output holding register.
    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        logic w_ov_k;

        if (k == 0) begin : g_src_integ
            assign w_cx[0] = w_integ[ORDER-1];
            assign w_cv[0] = r_dec_stb;
        end

        cic_comb_stage #(.W(ACC_W)) u_stage (
            .CLK       (CLK),
            .RST       (RST),
            .in_valid  (w_cv[k]),
            .x         (w_cx[k]),
            .out_valid (w_ov_k),
            .y         (w_cy[k])
        );

        assign w_ov[k] = w_ov_k;

        if (k < ORDER - 1) begin : g_pipe
            logic signed [ACC_W-1:0] r_py;
            logic                    r_pv;

            // Inter-stage pipeline register; never stalls.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    r_py <= '0;
                    r_pv <= 1'b0;
                end else begin
                    r_pv <= w_ov_k;
                    if (w_ov_k) begin
                        r_py <= w_cy[k];
                    end
                end
            end

            assign w_cx[k+1] = r_py;
            assign w_cv[k+1] = r_pv;
        end
    end

    for (genvar k = ORDER; k < ORDER_MAX; k++) begin : g_ov_pad
        assign w_ov[k] = 1'b0;
    end

    assign w_res       = w_cy[ORDER-1];
    assign w_res_v     = |(w_ov & C_LAST_MASK);
    assign w_overwrite = w_res_v && r_dout_valid && !bus.dout_ready;

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovr        <= 1'b0;
        end else if (w_res_v) begin
            r_dout       <= w_res;
            r_dout_valid <= 1'b1;
            if (w_overwrite) begin
                r_ovr <= 1'b1;
            end
        end else if (r_dout_valid && bus.dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.ovr        = r_ovr;

`ifdef CIC_OVR_CNT_EN
    logic [7:0] r_ovr_cnt;

    // Saturating count of results that replaced an unaccepted sample.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ovr_cnt <= '0;
        end else if (w_overwrite && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign bus.ovr_cnt = r_ovr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cic_decimator.sv
// ============================================================================
// Module  : tb_cic_decimator
// Brief   : Self-checking bench for cic_decimator (defaults ORDER=3, R=16)
//           with a sample-indexed reference CIC model feeding a scoreboard.
//           Overwrite-counter checks are active when CIC_OVR_CNT_EN is set.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cic_decimator;
    import cic_pkg::*;

    localparam int ORDER    = 3;
    localparam int DEC_LOG2 = 4;
    localparam int R        = 1 << DEC_LOG2;
    localparam int ACC_W    = cic_acc_w(ORDER, DEC_LOG2);
    localparam int GAIN     = 1 << (ORDER * DEC_LOG2);
    localparam int NBITS    = 10 * R;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    cic_decimator_if #(.ORDER(ORDER), .DEC_LOG2(DEC_LOG2)) bus ();

    cic_decimator #(.ORDER(ORDER), .DEC_LOG2(DEC_LOG2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 1'b0;
    int  exp_q[$];
    int  got[$];
    int  ref_run[$];
    bit  bits_tab [NBITS];

    logic signed [ACC_W-1:0] m_i [ORDER];
    logic signed [ACC_W-1:0] m_d [ORDER];
    int                      m_n;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < ORDER; k++) begin
            m_i[k] = '0;
            m_d[k] = '0;
        end
        m_n = 0;
        exp_q.delete();
        got.delete();
    endtask

    // Reference CIC: registered integrator cascade, decimate every R-th sample,
    // then ORDER comb sections, all in ACC_W-bit wrapping arithmetic.
    task automatic model_push(input bit b);
        logic signed [ACC_W-1:0] x;
        logic signed [ACC_W-1:0] c;
        logic signed [ACC_W-1:0] y;
        x = b ? ACC_W'(1) : {ACC_W{1'b1}};
        for (int k = ORDER - 1; k >= 1; k--) m_i[k] = m_i[k] + m_i[k-1];
        m_i[0] = m_i[0] + x;
        m_n++;
        if (m_n % R == 0) begin
            c = m_i[ORDER-1];
            for (int k = 0; k < ORDER; k++) begin
                y      = c - m_d[k];
                m_d[k] = c;
                c      = y;
            end
            exp_q.push_back(int'(c));
        end
    endtask

    task automatic send(input bit b);
        @(posedge CLK);
        #1;
        bus.din       = b;
        bus.din_valid = 1'b1;
        model_push(b);
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic reset_dut();
        bus.din_valid = 1'b0;
        RST = 1'b0;
        model_clear();
        wait_edges(2);
        RST = 1'b1;
    endtask

    // Scoreboard: every accepted sample is popped and compared in order.
    always @(negedge CLK) begin
        if (mon_en && RST && bus.dout_valid && bus.dout_ready) begin
            chk("sb_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk("sb_dout", int'(bus.dout), exp_q.pop_front());
                got.push_back(int'(bus.dout));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  a;
        int  b;
        int  idx;
        bit  seen;

        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < NBITS; i++) bits_tab[i] = 1'($urandom());

        // Reset state
        model_clear();
        wait_edges(2);
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_dout_valid", int'(bus.dout_valid), 0);
        chk("rst_ovr", int'(bus.ovr), 0);
`ifdef CIC_OVR_CNT_EN
        chk("rst_ovr_cnt", int'(bus.ovr_cnt), 0);
`endif
        RST    = 1'b1;
        mon_en = 1'b1;

        // All-ones: latency, pulse count and DC gain
        for (int i = 0; i < R; i++) send(1'b1);
        idle();
        n = 0;
        while (!bus.dout_valid && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("latency", n, ORDER);
        for (int i = 0; i < 11 * R; i++) send(1'b1);
        idle();
        wait_edges(ORDER + 3);
        chk("ones_count", got.size(), 12);
        for (int i = 4; i < 12; i++) chk("ones_dc", got[i], GAIN);

        // All-zeros
        reset_dut();
        for (int i = 0; i < 8 * R; i++) send(1'b0);
        idle();
        wait_edges(ORDER + 3);
        for (int i = 4; i < 8; i++) chk("zeros_dc", got[i], -GAIN);

        // Alternating 1/0
        reset_dut();
        for (int i = 0; i < 8 * R; i++) send(i % 2 == 0);
        idle();
        wait_edges(ORDER + 3);
        for (int i = 4; i < 8; i++) chk("alt_dc", got[i], 0);

        // Random bitstream, dense then with ~30% din_valid duty
        reset_dut();
        for (int i = 0; i < NBITS; i++) send(bits_tab[i]);
        idle();
        wait_edges(ORDER + 3);
        chk("dense_count", got.size(), NBITS / R);
        ref_run = got;
        reset_dut();
        idx = 0;
        while (idx < NBITS) begin
            if ($urandom_range(0, 99) < 30) begin
                send(bits_tab[idx]);
                idx++;
            end else begin
                idle();
            end
        end
        idle();
        wait_edges(ORDER + 3);
        chk("gap_count", got.size(), NBITS / R);
        for (int i = 0; i < NBITS / R; i++) chk("gap_vs_dense", got[i], ref_run[i]);

        // Reset two cycles after the decimation sample discards the pending result
        reset_dut();
        for (int i = 0; i < R; i++) send(bits_tab[i]);
        idle();
        wait_edges(2);
        RST = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (bus.dout_valid) seen = 1'b1;
        end
        chk("midrst_dout", int'(bus.dout), 0);
        RST = 1'b1;
        repeat (ORDER + 4) begin
            @(posedge CLK);
            #1;
            if (bus.dout_valid) seen = 1'b1;
        end
        chk("midrst_no_pulse", int'(seen), 0);
        for (int i = 0; i < 4 * R; i++) send(bits_tab[i]);
        idle();
        wait_edges(ORDER + 3);
        chk("midrst_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("midrst_vs_fresh", got[i], ref_run[i]);

        // Result coincident with handshake, then handshake alone
        reset_dut();
        mon_en         = 1'b0;
        bus.dout_ready = 1'b0;
        for (int i = 0; i < R; i++) send(bits_tab[i]);
        idle();
        wait_edges(ORDER);
        chk("hold_valid", int'(bus.dout_valid), 1);
        for (int i = R; i < 2 * R; i++) send(bits_tab[i]);
        idle();
        wait_edges(ORDER - 1);
        bus.dout_ready = 1'b1;
        wait_edges(1);
        bus.dout_ready = 1'b0;
        a = exp_q.pop_front();
        b = exp_q.pop_front();
        chk("coinc_dout", int'(bus.dout), b);
        chk("coinc_valid", int'(bus.dout_valid), 1);
        chk("coinc_ovr", int'(bus.ovr), 0);
        bus.dout_ready = 1'b1;
        wait_edges(1);
        bus.dout_ready = 1'b0;
        chk("hs_valid_fall", int'(bus.dout_valid), 0);
        chk("hs_dout_hold", int'(bus.dout), b);

        // Overwrite of an unaccepted sample
        for (int i = 2 * R; i < 3 * R; i++) send(bits_tab[i]);
        idle();
        wait_edges(ORDER);
        chk("first_no_ovr", int'(bus.ovr), 0);
        for (int i = 3 * R; i < 4 * R; i++) send(bits_tab[i]);
        idle();
        wait_edges(ORDER);
        a = exp_q.pop_front();
        b = exp_q.pop_front();
        chk("ovr_set", int'(bus.ovr), 1);
        chk("ovr_dout", int'(bus.dout), b);
`ifdef CIC_OVR_CNT_EN
        chk("ovr_cnt_one", int'(bus.ovr_cnt), 1);
        for (int i = 0; i < 300 * R; i++) send(i % 3 == 0);
        idle();
        wait_edges(ORDER + 3);
        chk("ovr_cnt_sat", int'(bus.ovr_cnt), 255);
`endif
        bus.dout_ready = 1'b1;
        wait_edges(2);
        chk("ovr_sticky", int'(bus.ovr), 1);
        exp_q.delete();

        // Reset clears the sticky flag
        reset_dut();
        chk("final_ovr", int'(bus.ovr), 0);
`ifdef CIC_OVR_CNT_EN
        chk("final_ovr_cnt", int'(bus.ovr_cnt), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
